// File: rtl/aes_result_fifo.sv
// aes_result_fifo
// Collects final-round AES blocks from the round pipeline into a small
// show-ahead FIFO. A pipeline block counts as a result only when its Rcon tag
// matches LAST_RCON; blocks still in intermediate rounds pass by unseen.
// A result that arrives while the FIFO is full and not draining is dropped,
// and the sticky overflow flag records that. blk_cnt counts accepted results
// and saturates.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.

module aes_result_fifo #(
  parameter int          DEPTH     = 4,
  parameter int          DATA_W    = 128,
  parameter logic [7:0]  LAST_RCON = 8'h36
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [7:0]                 in_rcon,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
  output logic [15:0]                blk_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
  localparam logic [15:0]   C_BLK_MAX = 16'hFFFF;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic [15:0]       r_blk_cnt;

  logic w_cand;
  logic w_pop;
  logic w_full;
  logic w_accept;
  logic w_drop;

  // Classify this cycle: candidate result, pop, and whether the candidate fits.
  // A full FIFO still takes a result when the head leaves in the same cycle.
  always_comb begin
    w_cand   = in_valid && (in_rcon == LAST_RCON);
    w_full   = (r_count == C_DEPTH);
    w_pop    = (r_count != '0) && out_ready;
    w_accept = w_cand && (!w_full || w_pop);
    w_drop   = w_cand && !w_accept;
  end

  // Storage array; not reset since out_data is only meaningful with out_valid.
  // The reset_n gate keeps a clock edge during reset from writing.
  always_ff @(posedge clock) begin
    if (reset_n && w_accept) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Pointers and occupancy; pointer wrap comes from the power-of-two depth.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky drop flag; cleared only by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // Saturating count of accepted results.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_blk_cnt <= '0;
    end else if (w_accept && (r_blk_cnt != C_BLK_MAX)) begin
      r_blk_cnt <= r_blk_cnt + 16'd1;
    end
  end

  // Show-ahead outputs straight from registered state.
  always_comb begin
    out_valid = (r_count != '0);
    out_data  = r_mem[r_rd_ptr];
    count     = r_count;
    full      = w_full;
    overflow  = r_overflow;
    blk_cnt   = r_blk_cnt;
  end

endmodule

// File: tb/tb_aes_result_fifo.sv
module tb_aes_result_fifo;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 128;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic [7:0]        in_rcon;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        count;
  logic              full;
  logic              overflow;
  logic [15:0]       blk_cnt;

  int checks   = 0;
  int failures = 0;

  // reference model
  logic [DATA_W-1:0] sb[$];
  int                m_count = 0;
  int                m_blk   = 0;
  bit                m_ovf   = 1'b0;

  aes_result_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .LAST_RCON(8'h36)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_rcon  (in_rcon),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count),
    .full     (full),
    .overflow (overflow),
    .blk_cnt  (blk_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic [DATA_W-1:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // advance the model with the current inputs, then cross one rising edge
  task automatic step();
    bit pop, cand, acc;
    pop  = (m_count != 0) && out_ready;
    cand = in_valid && (in_rcon == 8'h36);
    acc  = cand && ((m_count < DEPTH) || pop);
    if (pop) void'(sb.pop_front());
    if (acc) sb.push_back(in_data);
    m_count = m_count + int'(acc) - int'(pop);
    if (acc && m_blk < 65535) m_blk++;
    if (cand && !acc) m_ovf = 1'b1;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic model_clear();
    sb.delete();
    m_count = 0;
    m_blk   = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    model_clear();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_rcon = 8'h00; in_data = '0; out_ready = 1'b0;
    #3;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || full !== 1'b0 || overflow !== 1'b0 || blk_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_state count=%0d out_valid=%0b full=%0b overflow=%0b blk_cnt=%0d expected all zero",
               count, out_valid, full, overflow, blk_cnt);
    end
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_ignore_rcon();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_rcon = 8'h1B; in_data = rnd_blk(); out_ready = 1'b0;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd0 || blk_cnt !== 16'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ignore_rcon count=%0d blk_cnt=%0d out_valid=%0b expected 0/0/0", count, blk_cnt, out_valid);
    end
  endtask

  task automatic test_stall_hold();
    logic [DATA_W-1:0] a;
    a = rnd_blk();
    in_valid = 1'b1; in_rcon = 8'h36; in_data = a; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== a || count !== 3'd1) begin
      failures++;
      $display("FAIL first_write out_valid=%0b count=%0d data=%h expected 1/1/%h", out_valid, count, out_data, a);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== a) begin
        failures++;
        $display("FAIL stall_hold cycle %0d out_valid=%0b data=%h expected 1/%h", i, out_valid, out_data, a);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10 && m_count != 0; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== sb[0]) begin
        failures++;
        $display("FAIL stall_drain data=%h expected %h", out_data, sb[0]);
      end
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 3'(m_count) || m_count != 0) begin
      failures++;
      $display("FAIL stall_drain_empty count=%0d expected 0", count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_rcon = 8'h36; in_data = rnd_blk(); out_ready = 1'b0;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL fill full=%0b count=%0d overflow=%0b expected 1/4/0", full, count, overflow);
    end
    in_valid = 1'b1; in_data = rnd_blk();
    step();
    in_valid = 1'b0;
    checks++;
    if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b1 || blk_cnt !== 16'd4) begin
      failures++;
      $display("FAIL overflow full=%0b count=%0d overflow=%0b blk_cnt=%0d expected 1/4/1/4",
               full, count, overflow, blk_cnt);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10 && m_count != 0; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== sb[0]) begin
        failures++;
        $display("FAIL overflow_drain data=%h expected %h", out_data, sb[0]);
      end
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_after_drain out_valid=%0b count=%0d overflow=%0b expected 0/0/1",
               out_valid, count, overflow);
    end
  endtask

  task automatic test_full_pushpop();
    logic [DATA_W-1:0] e;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_rcon = 8'h36; in_data = rnd_blk(); out_ready = 1'b0;
      step();
    end
    e = rnd_blk();
    in_data = e; out_ready = 1'b1;
    checks++;
    if (out_data !== sb[0]) begin
      failures++;
      $display("FAIL full_pushpop_head data=%h expected %h", out_data, sb[0]);
    end
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (overflow !== 1'b0 || count !== 3'd4 || full !== 1'b1 || blk_cnt !== 16'd5) begin
      failures++;
      $display("FAIL full_pushpop overflow=%0b count=%0d full=%0b blk_cnt=%0d expected 0/4/1/5",
               overflow, count, full, blk_cnt);
    end
    checks++;
    if (sb[DEPTH-1] !== e) begin
      failures++;
      $display("FAIL full_pushpop_model tail=%h expected %h", sb[DEPTH-1], e);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10 && m_count != 0; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== sb[0]) begin
        failures++;
        $display("FAIL full_pushpop_order data=%h expected %h", out_data, sb[0]);
      end
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_pushpop_empty count=%0d out_valid=%0b expected 0/0", count, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_rcon = 8'h36; in_data = rnd_blk(); out_ready = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_rcon = 8'h36; in_data = rnd_blk(); out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== sb[0] || count !== 3'd1) begin
        failures++;
        $display("FAIL back_to_back cycle %0d out_valid=%0b count=%0d data=%h expected 1/1/%h",
                 i, out_valid, count, out_data, sb[0]);
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== sb[0]) begin
      failures++;
      $display("FAIL back_to_back_last data=%h expected %h", out_data, sb[0]);
    end
    step();
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || blk_cnt !== 16'(m_blk)) begin
      failures++;
      $display("FAIL back_to_back_end count=%0d blk_cnt=%0d expected 0/%0d", count, blk_cnt, m_blk);
    end
  endtask

  task automatic test_async_reset();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_rcon = 8'h36; in_data = rnd_blk(); out_ready = 1'b0;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd3) begin
      failures++;
      $display("FAIL async_pre count=%0d expected 3", count);
    end
    #2 reset_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || blk_cnt !== 16'd0 || full !== 1'b0) begin
      failures++;
      $display("FAIL async_reset count=%0d out_valid=%0b overflow=%0b blk_cnt=%0d full=%0b expected zeros",
               count, out_valid, overflow, blk_cnt, full);
    end
    #1 reset_n = 1'b1;
    d = rnd_blk();
    in_valid = 1'b1; in_rcon = 8'h36; in_data = d;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== d || count !== 3'd1 || blk_cnt !== 16'd1) begin
      failures++;
      $display("FAIL async_after_release out_valid=%0b count=%0d blk_cnt=%0d data=%h expected 1/1/1/%h",
               out_valid, count, blk_cnt, out_data, d);
    end
  endtask

  initial begin
    test_reset();
    test_ignore_rcon();
    test_stall_hold();
    test_overflow();
    test_full_pushpop();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_result_fifo.md
AES_RESULT_FIFO -- requirements
Module: aes_result_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning FIFO entry count; the value SHALL be a power of two and at least 2.
REQ-002 The block SHALL have parameter DATA_W, default 128, meaning ciphertext block width.
REQ-003 The block SHALL have parameter LAST_RCON, default 8'h36, meaning the Rcon value that tags a final-round block.
REQ-004 The block SHALL have port clock, input, 1 bit: single clock, rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the final pipeline register presents a block this cycle.
REQ-007 The block SHALL have port in_rcon, input, 8 bits: Rcon carried alongside the block by the round pipeline.
REQ-008 The block SHALL have port in_data, input, DATA_W bits: state after AddRoundKey.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the head entry is available.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the head entry.
REQ-011 The block SHALL have port out_data, output, DATA_W bits: the head ciphertext.
REQ-012 The block SHALL have port count, output, clog2(DEPTH)+1 bits: number of occupied entries.
REQ-013 The block SHALL have port full, output, 1 bit: count equals DEPTH.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky flag for a dropped final block.
REQ-015 The block SHALL have port blk_cnt, output, 16 bits: saturating count of accepted blocks.

Function
REQ-016 A candidate write SHALL occur when in_valid=1 and in_rcon=LAST_RCON; in_valid=1 with any other in_rcon SHALL be ignored, because the block is still in an intermediate round.
REQ-017 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-018 A candidate write SHALL be accepted when count<DEPTH, or when count=DEPTH and a pop occurs in the same cycle.
REQ-019 A candidate write SHALL otherwise be dropped, with no state change except that overflow is set to 1.
REQ-020 An accepted write SHALL store in_data at the write pointer and advance the write pointer modulo DEPTH.
REQ-021 A pop SHALL advance the read pointer modulo DEPTH.
REQ-022 count SHALL increment on write-only, decrement on pop-only, and stay unchanged on simultaneous write and pop.
REQ-023 The interface SHALL be show-ahead: out_data SHALL equal the entry at the read pointer, and out_valid SHALL equal (count!=0).
REQ-024 Latency SHALL be 1 cycle: a write into an empty FIFO at edge N SHALL give out_valid=1 with that data after edge N.
REQ-025 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable.
REQ-026 When count=1 with simultaneous write and pop, the old entry SHALL be consumed, the new entry SHALL become head, and out_valid SHALL stay 1.
REQ-027 A pop SHALL never occur when count=0; out_ready while out_valid=0 SHALL have no effect.
REQ-028 blk_cnt SHALL increment by 1 on each accepted write and saturate at 16'hFFFF.
REQ-029 overflow SHALL remain set until reset.
REQ-030 full SHALL be combinational from count.

Reset
REQ-031 When reset_n=0, the block SHALL immediately, regardless of clock, set both pointers=0, count=0, out_valid=0, full=0, overflow=0 and blk_cnt=0.
REQ-032 out_data SHALL be don't-care while out_valid=0; storage contents need not be cleared.
REQ-033 Reset asserted mid-operation SHALL discard all stored blocks; a write presented in the cycle reset deasserts SHALL be handled normally on the next rising edge.
REQ-034 The block SHALL perform no writes or pops while reset_n=0.

Verification
REQ-035 Scenario: in_valid=1, in_rcon=8'h1B, data X -> no write; count=0; blk_cnt=0.
REQ-036 Scenario: write A (rcon 8'h36) with out_ready=0 -> next cycle out_valid=1, out_data=A, count=1; A holds stable for 5 stalled cycles.
REQ-037 Scenario: write 4 blocks with out_ready=0, then a 5th -> full=1, count=4, overflow=1, blk_cnt=4; the 5th block is never output.
REQ-038 Scenario: full FIFO, write E with simultaneous pop -> E accepted, overflow=0, count=4; output order is the original 4 blocks then E.
REQ-039 Scenario: count=1, simultaneous write and pop every cycle for 10 cycles -> out_valid stays 1 and data is returned in order.
REQ-040 Scenario: reset_n pulsed low between clock edges with count=3 -> outputs reset immediately (count=0, out_valid=0, overflow=0, blk_cnt=0); the next write after release yields out_valid 1 cycle later.
